dsp_bus_qualifier: RTL

Front end of the FPGA's DSP parallel-bus slave. Synchronises the asynchronous DSP strobes (chip select, read, write) into `xclk` and rejects glitches. Latches the address and write data, then issues the single-cycle `read_qualified` / `write_qualified` pulses and the `ab` / `db_in` buses that every App block (timestamp/revision readback, stored values, etc.) decodes. It also generates the data-bus output enable used by the top-level bidirectional driver and flags illegal simultaneous read+write strobes.

---
 rtl/dsp_bus_qualifier.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/dsp_bus_qualifier.sv
// rtl/dsp_bus_qualifier.sv - DSP parallel-bus front end: strobe sync, glitch filter, qualified read/write pulses
module dsp_bus_qualifier #(
    parameter int SYNC_STAGES   = 2,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        xclk,
    input  logic        reset,
    input  logic        cs_n,
    input  logic        rd_n,
    input  logic        we_n,
    input  logic [7:0]  ab_pins,
    input  logic [15:0] db_pins_in,
    output logic [7:0]  ab,
    output logic [15:0] db_in,
    output logic        read_qualified,
    output logic        write_qualified,
    output logic        db_oe,
    output logic        bus_error
);

    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_QUAL, ST_WAIT_RELEASE} state_t;
    typedef enum logic [1:0] {KIND_NONE, KIND_RD, KIND_WR} kind_t;

    localparam logic [3:0] SETTLE_N = 4'(SETTLE_CYCLES);

    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] rd_sync_q, rd_sync_d;
    logic [SYNC_STAGES-1:0] we_sync_q, we_sync_d;
    logic [SYNC_STAGES-1:0] sync_valid_q, sync_valid_d;

    state_t      state_q, state_d;
    kind_t       kind_q, kind_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  ab_q, ab_d;
    logic [15:0] db_in_q, db_in_d;
    logic        read_qual_q, read_qual_d;
    logic        write_qual_q, write_qual_d;
    logic        db_oe_q, db_oe_d;
    logic        bus_error_q, bus_error_d;

    logic cs_s, rd_s, we_s;
    logic rd_act, wr_act, conflict, same_act, released;

    assign cs_s = cs_sync_q[SYNC_STAGES-1];
    assign rd_s = rd_sync_q[SYNC_STAGES-1];
    assign we_s = we_sync_q[SYNC_STAGES-1];

    assign rd_act   = !cs_s && !rd_s &&  we_s;
    assign wr_act   = !cs_s && !we_s &&  rd_s;
    assign conflict = !cs_s && !rd_s && !we_s;
    assign same_act = (kind_q == KIND_RD && rd_act) || (kind_q == KIND_WR && wr_act);

    // KIND_NONE (after reset or a conflict) waits for both strobes, so a strobe held across reset is never qualified.
    assign released = cs_s
                   || (kind_q == KIND_RD   && rd_s)
                   || (kind_q == KIND_WR   && we_s)
                   || (kind_q == KIND_NONE && rd_s && we_s);

    always_comb begin
        cs_sync_d    = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
        rd_sync_d    = {rd_sync_q[SYNC_STAGES-2:0], rd_n};
        we_sync_d    = {we_sync_q[SYNC_STAGES-2:0], we_n};
        sync_valid_d = {sync_valid_q[SYNC_STAGES-2:0], 1'b1};

        state_d      = state_q;
        kind_d       = kind_q;
        cnt_d        = cnt_q;
        ab_d         = ab_q;
        db_in_d      = db_in_q;
        read_qual_d  = 1'b0;
        write_qual_d = 1'b0;
        db_oe_d      = db_oe_q;
        // The all-asserted reset value of the synchroniser is not a real conflict; ignore it until flushed.
        bus_error_d  = bus_error_q | (conflict & sync_valid_q[SYNC_STAGES-1]);

        case (state_q)
            ST_IDLE: begin
                if (rd_act || wr_act) begin
                    state_d = ST_SETTLE;
                    kind_d  = rd_act ? KIND_RD : KIND_WR;
                    cnt_d   = 4'd1;
                end else if (conflict) begin
                    state_d = ST_WAIT_RELEASE;
                    kind_d  = KIND_NONE;
                end
            end
            ST_SETTLE: begin
                if (same_act) begin
                    if (cnt_q == SETTLE_N) begin
                        state_d = ST_QUAL;
                        ab_d    = ab_pins;
                        if (kind_q == KIND_WR) begin
                            db_in_d      = db_pins_in;
                            write_qual_d = 1'b1;
                        end else begin
                            read_qual_d = 1'b1;
                            db_oe_d     = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end else if (conflict) begin
                    state_d = ST_WAIT_RELEASE;
                    kind_d  = KIND_NONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_QUAL: begin
                state_d = ST_WAIT_RELEASE;
            end
            ST_WAIT_RELEASE: begin
                if (released) begin
                    state_d = ST_IDLE;
                    db_oe_d = 1'b0;
                end else if (kind_q == KIND_RD && !we_s) begin
                    db_oe_d = 1'b0;
                end
            end
            default: state_d = ST_WAIT_RELEASE;
        endcase
    end

    always_ff @(posedge xclk) begin
        if (reset) begin
            cs_sync_q    <= '0;
            rd_sync_q    <= '0;
            we_sync_q    <= '0;
            sync_valid_q <= '0;
            state_q      <= ST_WAIT_RELEASE;
            kind_q       <= KIND_NONE;
            cnt_q        <= 4'd0;
            ab_q         <= 8'h00;
            db_in_q      <= 16'h0000;
            read_qual_q  <= 1'b0;
            write_qual_q <= 1'b0;
            db_oe_q      <= 1'b0;
            bus_error_q  <= 1'b0;
        end else begin
            cs_sync_q    <= cs_sync_d;
            rd_sync_q    <= rd_sync_d;
            we_sync_q    <= we_sync_d;
            sync_valid_q <= sync_valid_d;
            state_q      <= state_d;
            kind_q       <= kind_d;
            cnt_q        <= cnt_d;
            ab_q         <= ab_d;
            db_in_q      <= db_in_d;
            read_qual_q  <= read_qual_d;
            write_qual_q <= write_qual_d;
            db_oe_q      <= db_oe_d;
            bus_error_q  <= bus_error_d;
        end
    end

    assign ab              = ab_q;
    assign db_in           = db_in_q;
    assign read_qualified  = read_qual_q;
    assign write_qualified = write_qual_q;
    assign db_oe           = db_oe_q;
    assign bus_error       = bus_error_q;

endmodule
